// File: rtl/clb_config_loader.sv
// Serial configuration loader for the CLB array: hunts for a sync byte, shifts in
// NUM_CLB frames into a shadow register and commits them atomically on good even parity.
module clb_config_loader #(
  parameter int unsigned NUM_CLB    = 1,
  parameter int unsigned FRAME_BITS = 37,
  parameter logic [7:0]  SYNC       = 8'hB5
) (
  input  logic                          K,
  input  logic                          RST,
  input  logic                          DIN,
  input  logic                          DVALID,
  output logic [NUM_CLB*FRAME_BITS-1:0] CFG_OUT,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR
);

  localparam int unsigned TOTAL_BITS = NUM_CLB * FRAME_BITS;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BITS - 1);
  localparam logic [FRAME_BITS-1:0] DEFAULT_FRAME = FRAME_BITS'(37'h00_380A_80116);
  localparam logic [TOTAL_BITS-1:0] DEFAULT_CFG   = {NUM_CLB{DEFAULT_FRAME}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            win_q, win_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
  logic [TOTAL_BITS-1:0] cfg_q, cfg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // State and datapath registers
  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      shadow_q <= DEFAULT_CFG;
      cfg_q    <= DEFAULT_CFG;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; nothing advances on edges without DVALID
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = done_q;
    err_d    = err_q;

    if (DVALID) begin
      unique case (state_q)
        S_IDLE: begin
          win_d = {win_q[6:0], DIN};
          if (win_d == SYNC) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            par_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          shadow_d[cnt_q] = DIN;
          par_d           = par_q ^ DIN;
          if (cnt_q == LAST_IDX) begin
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (DIN == par_q) begin
            cfg_d  = shadow_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = S_IDLE;
          win_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          win_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign CFG_OUT = cfg_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader with NUM_CLB=2: table of full loads plus
// hand sequences for reset, DVALID gaps, sliding sync and reset mid-load.
module tb_clb_config_loader;

  localparam int unsigned NCLB = 2;
  localparam int unsigned W    = NCLB * 37;
  localparam logic [W-1:0] DEF2 = {2{37'h00_380A_80116}};
  localparam logic [7:0]   SYNC_B = 8'hB5;

  typedef struct {
    logic [W-1:0] payload;
    logic         par;
    logic         gap;
    logic [W-1:0] exp_cfg;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  logic         K = 1'b0;
  logic         RST;
  logic         DIN;
  logic         DVALID;
  logic [W-1:0] CFG_OUT;
  logic         BUSY;
  logic         DONE;
  logic         ERR;

  int n_checks = 0;
  int n_fail   = 0;

  clb_config_loader #(.NUM_CLB(NCLB)) u_dut (
    .K      (K),
    .RST    (RST),
    .DIN    (DIN),
    .DVALID (DVALID),
    .CFG_OUT(CFG_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 K = ~K;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One valid bit, optionally preceded by random DVALID=0 cycles that must not change outputs
  task automatic drive_bit(input logic b, input logic gap);
    logic [W-1:0] cfg_s;
    logic         busy_s, done_s, err_s;
    if (gap) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        @(negedge K);
        cfg_s = CFG_OUT; busy_s = BUSY; done_s = DONE; err_s = ERR;
        DIN = 1'($urandom_range(0, 1));
        DVALID = 1'b0;
        @(posedge K); #1;
        chk("gap_hold", {CFG_OUT, BUSY, DONE, ERR}, {cfg_s, busy_s, done_s, err_s});
      end
    end
    @(negedge K);
    DIN = b;
    DVALID = 1'b1;
    @(posedge K); #1;
  endtask

  task automatic send_sync(input logic gap);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(SYNC_B[i], gap);
      if (i > 0) chk("busy_before_sync", W'(BUSY), W'(1'b0));
    end
    chk("busy_on_sync", W'(BUSY), W'(1'b1));
    chk("flags_clear_on_sync", W'({DONE, ERR}), W'(2'b00));
  endtask

  task automatic do_load(input logic [W-1:0] payload, input logic par, input logic gap,
                         input logic [W-1:0] exp_cfg, input logic exp_done, input logic exp_err);
    int           busy_cnt;
    logic [W-1:0] cfg_before;
    logic         cfg_moved;
    send_sync(gap);
    busy_cnt   = 1;
    cfg_before = CFG_OUT;
    cfg_moved  = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      drive_bit(payload[k], gap);
      busy_cnt += int'(BUSY);
      if (CFG_OUT !== cfg_before) cfg_moved = 1'b1;
    end
    chk("no_partial_cfg", W'(cfg_moved), W'(1'b0));
    drive_bit(par, gap);
    chk("busy_cycles", W'(busy_cnt), W'(75));
    chk("busy_after_commit", W'(BUSY), W'(1'b0));
    chk("cfg_out", CFG_OUT, exp_cfg);
    chk("done", W'(DONE), W'(exp_done));
    chk("err", W'(ERR), W'(exp_err));
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{payload: {37'h0, 37'h1}, par: 1'b0, gap: 1'b0,
                exp_cfg: DEF2, exp_done: 1'b0, exp_err: 1'b1};
    vecs[1] = '{payload: {37'h0, 37'h1}, par: 1'b1, gap: 1'b0,
                exp_cfg: {37'h0, 37'h1}, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{payload: {37'h1F_FFFF_FFFF, 37'h00_1234_5678}, par: 1'b0, gap: 1'b1,
                exp_cfg: {37'h1F_FFFF_FFFF, 37'h00_1234_5678}, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{payload: {37'h0, 37'h00_0000_00AD}, par: 1'b1, gap: 1'b0,
                exp_cfg: {37'h0, 37'h00_0000_00AD}, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{payload: {37'h15_5555_5555, 37'h0}, par: 1'b0, gap: 1'b0,
                exp_cfg: {37'h0, 37'h00_0000_00AD}, exp_done: 1'b0, exp_err: 1'b1};

    RST = 1'b1; DIN = 1'b0; DVALID = 1'b0;
    repeat (3) @(posedge K);
    #1;
    chk("rst_cfg", CFG_OUT, DEF2);
    chk("rst_flags", W'({BUSY, DONE, ERR}), W'(3'b000));

    @(negedge K);
    RST = 1'b0;
    // Sync pattern presented with DVALID low must be ignored
    for (int i = 7; i >= 0; i--) begin
      @(negedge K);
      DIN = SYNC_B[i];
      DVALID = 1'b0;
      @(posedge K); #1;
      chk("idle_hold_cfg", CFG_OUT, DEF2);
      chk("idle_hold_flags", W'({BUSY, DONE, ERR}), W'(3'b000));
    end

    // Sliding sync: 1,1 then B5 gives stream 1,1,1,0,1,1,0,1,0,1
    drive_bit(1'b1, 1'b0);
    chk("slide_busy1", W'(BUSY), W'(1'b0));
    drive_bit(1'b1, 1'b0);
    chk("slide_busy2", W'(BUSY), W'(1'b0));

    // Vectors run back-to-back; vec3 carries B5 in serial payload order
    for (int v = 0; v < 5; v++) begin
      do_load(vecs[v].payload, vecs[v].par, vecs[v].gap,
              vecs[v].exp_cfg, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Good load, then reset after 20 payload bits of the next one
    do_load(vecs[1].payload, 1'b1, 1'b0, vecs[1].exp_cfg, 1'b1, 1'b0);
    send_sync(1'b0);
    for (int k = 0; k < 20; k++) drive_bit(1'b1, 1'b0);
    chk("midload_busy", W'(BUSY), W'(1'b1));
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_cfg", CFG_OUT, DEF2);
    chk("midrst_flags", W'({BUSY, DONE, ERR}), W'(3'b000));
    repeat (2) drive_bit(1'b1, 1'b0);
    chk("midrst_hold", {CFG_OUT, BUSY, DONE, ERR}, {DEF2, 3'b000});
    @(negedge K);
    RST = 1'b0;
    DVALID = 1'b0;
    do_load({37'h00_0000_0003, 37'h10_0000_0000}, 1'b1, 1'b0,
            {37'h00_0000_0003, 37'h10_0000_0000}, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
